bsg_masked_write_serializer: RTL and testbench

Accepts one wide write (els_p lanes of lane_width_p bits plus a per-lane bitmask) and serializes it onto a narrower write port of out_lanes_p lanes per beat, expanding each beat's lane mask into a per-bit write mask. It sits between a wide store producer and a narrow bit-masked SRAM or network write port, and is the sequencer for the lane-to-bit mask expansion datapath.

---
 rtl/bsg_masked_write_serializer.sv | 129 ++++++++++++
 tb/tb_bsg_masked_write_serializer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_masked_write_serializer.sv
// Splits one wide lane-masked write into narrow beats with per-bit write masks; first beat 1 cycle after accept, held until yumi_i.
// Define BSG_MASKED_WRITE_SERIALIZER_SKIP_EN to skip beats whose lane mask is all zero.
module bsg_masked_write_serializer #(
  parameter int els_p        = 16,
  parameter int lane_width_p = 32,
  parameter int out_lanes_p  = 4,
  localparam int beats_lp      = els_p / out_lanes_p,
  localparam int addr_width_lp = (beats_lp > 1) ? $clog2(beats_lp) : 1
) (
  input  logic                                clk_i,
  input  logic                                reset_i,
  input  logic                                v_i,
  input  logic [els_p*lane_width_p-1:0]       data_i,
  input  logic [els_p-1:0]                    mask_i,
  output logic                                ready_o,
  output logic                                v_o,
  output logic [out_lanes_p*lane_width_p-1:0] data_o,
  output logic [out_lanes_p*lane_width_p-1:0] wmask_o,
  output logic [addr_width_lp-1:0]            addr_o,
  output logic                                last_o,
  input  logic                                yumi_i
);

  localparam int beat_bits_lp = out_lanes_p * lane_width_p;

  localparam logic [0:0] idle_s = 1'b0;
  localparam logic [0:0] send_s = 1'b1;

  logic [0:0]                    state_r;
  logic [els_p*lane_width_p-1:0] data_r;
  logic [els_p-1:0]              mask_r;
  logic [addr_width_lp-1:0]      ptr_r;

  logic [beats_lp-1:0]      elig_in;
  logic [beats_lp-1:0]      elig_r;
  logic                     first_vld;
  logic [addr_width_lp-1:0] first_idx;
  logic                     next_vld;
  logic [addr_width_lp-1:0] next_idx;
  logic [out_lanes_p-1:0]   beat_mask;

  always_comb begin
    elig_in = '0;
    elig_r  = '0;
    for (int b = 0; b < beats_lp; b++) begin
`ifdef BSG_MASKED_WRITE_SERIALIZER_SKIP_EN
      elig_in[b] = |mask_i[b*out_lanes_p +: out_lanes_p];
      elig_r[b]  = |mask_r[b*out_lanes_p +: out_lanes_p];
`else
      elig_in[b] = 1'b1;
      elig_r[b]  = 1'b1;
`endif
    end
  end

  // Descending scans so the lowest qualifying beat wins.
  always_comb begin
    first_vld = 1'b0;
    first_idx = '0;
    next_vld  = 1'b0;
    next_idx  = '0;
    for (int b = beats_lp - 1; b >= 0; b--) begin
      if (elig_in[b]) begin
        first_vld = 1'b1;
        first_idx = addr_width_lp'(b);
      end
      if (elig_r[b] && (b > int'(ptr_r))) begin
        next_vld = 1'b1;
        next_idx = addr_width_lp'(b);
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r <= idle_s;
      data_r  <= '0;
      mask_r  <= '0;
      ptr_r   <= '0;
    end else begin
      case (state_r)
        idle_s: begin
          if (v_i) begin
            data_r <= data_i;
            mask_r <= mask_i;
            if (first_vld) begin
              state_r <= send_s;
              ptr_r   <= first_idx;
            end
          end
        end
        send_s: begin
          if (yumi_i) begin
            if (next_vld) begin
              ptr_r <= next_idx;
            end else begin
              state_r <= idle_s;
            end
          end
        end
        default: state_r <= idle_s;
      endcase
    end
  end

  always_comb begin
    data_o    = '0;
    beat_mask = '0;
    for (int b = 0; b < beats_lp; b++) begin
      if (ptr_r == addr_width_lp'(b)) begin
        data_o    = data_r[b*beat_bits_lp +: beat_bits_lp];
        beat_mask = mask_r[b*out_lanes_p +: out_lanes_p];
      end
    end
  end

  always_comb begin
    wmask_o = '0;
    for (int l = 0; l < out_lanes_p; l++) begin
      wmask_o[l*lane_width_p +: lane_width_p] = {lane_width_p{beat_mask[l]}};
    end
  end

  assign ready_o = (state_r == idle_s);
  assign v_o     = (state_r == send_s);
  assign addr_o  = ptr_r;
  assign last_o  = v_o & ~next_vld;

endmodule

// File: tb/tb_bsg_masked_write_serializer.sv
// Bench for bsg_masked_write_serializer: directed table, reset/backpressure sequences, and randomized scoreboard runs.
module tb_bsg_masked_write_serializer;

`ifdef BSG_MASKED_WRITE_SERIALIZER_SKIP_EN
  localparam bit skip_c = 1'b1;
`else
  localparam bit skip_c = 1'b0;
`endif

  logic         clk_i = 1'b0;
  logic         reset_i = 1'b1;
  logic         v_i = 1'b0;
  logic [511:0] data_i = '0;
  logic [15:0]  mask_i = '0;
  logic         ready_o;
  logic         v_o;
  logic [127:0] data_o;
  logic [127:0] wmask_o;
  logic [1:0]   addr_o;
  logic         last_o;
  logic         yumi_i = 1'b0;

  bsg_masked_write_serializer #(.els_p(16), .lane_width_p(32), .out_lanes_p(4)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .v_i(v_i), .data_i(data_i), .mask_i(mask_i),
    .ready_o(ready_o), .v_o(v_o), .data_o(data_o), .wmask_o(wmask_o),
    .addr_o(addr_o), .last_o(last_o), .yumi_i(yumi_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [1:0]   addr;
    logic [127:0] data;
    logic [127:0] wmask;
    logic         last;
  } beat_t;

  typedef struct {
    logic [15:0] mask;
    bit          lane_k;
    int          stall_beat;
    int          stall_n;
    int          exp_n;
    int          exp_first;
  } vec_t;

  beat_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [511:0] lane_k_data();
    logic [511:0] r;
    for (int k = 0; k < 16; k++) r[k*32 +: 32] = k;
    return r;
  endfunction

  // Reference: list of beats a write should produce, built straight from the eligibility rule.
  task automatic push_write(input logic [511:0] d, input logic [15:0] m);
    int start;
    beat_t bt;
    start = sb.size();
    for (int b = 0; b < 4; b++) begin
      if (!skip_c || (m[b*4 +: 4] != 4'h0)) begin
        bt.addr = 2'(b);
        bt.data = d[b*128 +: 128];
        for (int j = 0; j < 128; j++) bt.wmask[j] = m[b*4 + j/32];
        bt.last = 1'b0;
        sb.push_back(bt);
      end
    end
    if (sb.size() > start) sb[sb.size()-1].last = 1'b1;
  endtask

  task automatic chk_beat(input string tag, input beat_t e);
    chk({tag, "_v"}, v_o, 1'b1);
    chk({tag, "_addr"}, addr_o, e.addr);
    chk({tag, "_data"}, data_o, e.data);
    chk({tag, "_wmask"}, wmask_o, e.wmask);
    chk({tag, "_last"}, last_o, e.last);
  endtask

  task automatic do_write(input logic [15:0] m, input logic [511:0] d, input int stall_beat,
                          input int stall_n, input int exp_n, input int exp_first);
    int n;
    chk("pre_ready", ready_o, 1'b1);
    chk("pre_v", v_o, 1'b0);
    sb.delete();
    push_write(d, m);
    v_i = 1'b1; data_i = d; mask_i = m; yumi_i = 1'b0;
    tick();
    v_i = 1'b0; data_i = rand512(); mask_i = 16'($urandom);
    n = 0;
    if (exp_n > 0) chk("first_addr", addr_o, exp_first);
    while (v_o === 1'b1 && n < 8) begin
      if (n < sb.size()) begin
        chk_beat("beat", sb[n]);
        chk("send_ready", ready_o, 1'b0);
        if (n == stall_beat) begin
          for (int s = 0; s < stall_n; s++) begin
            tick();
            chk_beat("stall", sb[n]);
            chk("stall_ready", ready_o, 1'b0);
          end
        end
      end else begin
        chk("extra_beat", v_o, 1'b0);
      end
      yumi_i = 1'b1;
      tick();
      yumi_i = 1'b0;
      n++;
    end
    chk("beat_count", n, exp_n);
    tick();
    chk("post_v", v_o, 1'b0);
    chk("post_ready", ready_o, 1'b1);
  endtask

  task automatic sb_cycle();
    chk("ready_vs_state", ready_o, !v_o);
    if (v_i && ready_o) push_write(data_i, mask_i);
    if (v_o) begin
      if (sb.size() == 0) begin
        chk("unexpected_beat", v_o, 1'b0);
      end else begin
        chk_beat("sb", sb[0]);
        if (yumi_i) void'(sb.pop_front());
      end
    end
  endtask

  vec_t tbl[8];

  initial begin
    int acc, cyc, nb;
    logic [15:0] m;

    tbl[0] = '{16'hFFFF, 1'b1, -1, 0, 4, 0};
    tbl[1] = '{16'h0102, 1'b1, -1, 0, skip_c ? 2 : 4, 0};
    tbl[2] = '{16'h0000, 1'b0, -1, 0, skip_c ? 0 : 4, 0};
    tbl[3] = '{16'hF000, 1'b0, -1, 0, skip_c ? 1 : 4, skip_c ? 3 : 0};
    tbl[4] = '{16'hFFFF, 1'b0, 1, 5, 4, 0};
    tbl[5] = '{16'h0010, 1'b0, 0, 3, skip_c ? 1 : 4, skip_c ? 1 : 0};
    tbl[6] = '{16'h8421, 1'b0, 3, 2, 4, 0};
    tbl[7] = '{16'h0F00, 1'b1, -1, 0, skip_c ? 1 : 4, skip_c ? 2 : 0};

    #2;
    chk("rst_ready", ready_o, 1'b1);
    chk("rst_v", v_o, 1'b0);
    chk("rst_last", last_o, 1'b0);
    chk("rst_addr", addr_o, 2'd0);
    chk("rst_wmask", wmask_o, '0);
    chk("rst_data", data_o, '0);
    tick();
    reset_i = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) begin
      do_write(tbl[i].mask, tbl[i].lane_k ? lane_k_data() : rand512(),
               tbl[i].stall_beat, tbl[i].stall_n, tbl[i].exp_n, tbl[i].exp_first);
    end

    // Full mask, lane k = k: beat 1 carries lanes 7..4.
    v_i = 1'b1; data_i = lane_k_data(); mask_i = 16'hFFFF;
    tick();
    v_i = 1'b0; yumi_i = 1'b1;
    tick();
    chk("b1_addr", addr_o, 2'd1);
    chk("b1_data", data_o, 128'h00000007_00000006_00000005_00000004);
    chk("b1_wmask", wmask_o, {128{1'b1}});
    chk("b1_last", last_o, 1'b0);
    tick();
    chk("b2_addr", addr_o, 2'd2);

    // Asynchronous reset in the middle of beat 2.
    reset_i = 1'b1;
    #1;
    chk("mid_rst_v", v_o, 1'b0);
    chk("mid_rst_ready", ready_o, 1'b1);
    chk("mid_rst_wmask", wmask_o, '0);
    chk("mid_rst_data", data_o, '0);
    chk("mid_rst_addr", addr_o, 2'd0);
    yumi_i = 1'b0;
    tick();
    reset_i = 1'b0;
    tick();
    do_write(16'hFFFF, rand512(), -1, 0, 4, 0);

    // Back-to-back: v_i held, yumi_i held, 100 writes of mask F000.
    sb.delete();
    nb = skip_c ? 1 : 4;
    acc = 0; cyc = 0;
    yumi_i = 1'b1;
    while (!(acc == 100 && sb.size() == 0) && cyc < 3000) begin
      v_i = (acc < 100); data_i = rand512(); mask_i = 16'hF000;
      if (v_i && ready_o) acc++;
      sb_cycle();
      tick();
      cyc++;
    end
    v_i = 1'b0; yumi_i = 1'b0;
    chk("b2b_accepts", acc, 100);
    chk("b2b_drain", sb.size(), 0);
    chk("b2b_cycles", cyc, 100 * (nb + 1));

    // Random traffic against the scoreboard.
    tick();
    sb.delete();
    for (int c = 0; c < 600; c++) begin
      case ($urandom_range(0, 3))
        0: m = 16'h0000;
        1: m = 16'hF << (4 * $urandom_range(0, 3));
        default: m = 16'($urandom);
      endcase
      v_i = ($urandom_range(0, 2) != 0); data_i = rand512(); mask_i = m;
      yumi_i = ($urandom_range(0, 3) != 0);
      sb_cycle();
      tick();
    end
    v_i = 1'b0; yumi_i = 1'b1;
    cyc = 0;
    while ((sb.size() != 0 || v_o) && cyc < 50) begin
      sb_cycle();
      tick();
      cyc++;
    end
    yumi_i = 1'b0;
    chk("rand_drain", sb.size(), 0);
    chk("rand_idle", v_o, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
